// File: rtl/rob.sv
// Reorder buffer: in-order allocate/commit with out-of-order writeback and a one-cycle flush on a mispredicted branch.
// Optional macro ROB_PERF_EN adds the perf_commits/perf_flushes counters.
`ifndef ROB_WIDTH
`define ROB_WIDTH 3
`endif

module rob #(
  parameter int ROB_WIDTH = `ROB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 dec_ready,
  input  logic [1:0]           dec_kind,
  input  logic [4:0]           dec_rd,
  input  logic [31:0]          dec_pred_pc,
  output logic [ROB_WIDTH-1:0] new_rob_id,
  output logic                 rob_full,
  input  logic                 rf_busy_j,
  input  logic [ROB_WIDTH-1:0] rf_dep_j,
  input  logic [31:0]          rf_val_j,
  input  logic                 rf_busy_k,
  input  logic [ROB_WIDTH-1:0] rf_dep_k,
  input  logic [31:0]          rf_val_k,
  output logic                 has_dep_j,
  output logic [ROB_WIDTH-1:0] dep_j,
  output logic [31:0]          val_j,
  output logic                 has_dep_k,
  output logic [ROB_WIDTH-1:0] dep_k,
  output logic [31:0]          val_k,
  input  logic                 rs_ready,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_value,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  output logic                 commit_valid,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_value,
  output logic                 commit_store,
  output logic                 clear,
  output logic [31:0]          redirect_pc
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]          perf_commits,
  output logic [31:0]          perf_flushes
`endif
);

  localparam int ROB_SIZE = 1 << ROB_WIDTH;
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_STORE  = 2'd2;
  localparam logic [ROB_WIDTH-1:0] PTR_ONE = {{(ROB_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ROB_WIDTH:0]   CNT_ONE = {{ROB_WIDTH{1'b0}}, 1'b1};
  localparam logic [ROB_WIDTH:0]   CNT_FULL = {1'b1, {ROB_WIDTH{1'b0}}};

  logic [ROB_SIZE-1:0]        busy_q, busy_d;
  logic [ROB_SIZE-1:0]        ready_q, ready_d;
  logic [ROB_SIZE-1:0][1:0]   kind_q, kind_d;
  logic [ROB_SIZE-1:0][4:0]   rd_q, rd_d;
  logic [ROB_SIZE-1:0][31:0]  value_q, value_d;
  logic [ROB_SIZE-1:0][31:0]  predPc_q, predPc_d;
  logic [ROB_WIDTH-1:0]       head_q, head_d;
  logic [ROB_WIDTH-1:0]       tail_q, tail_d;
  logic [ROB_WIDTH:0]         count_q, count_d;

  logic                       commitValid_q, commitValid_d;
  logic [ROB_WIDTH-1:0]       commitId_q, commitId_d;
  logic [4:0]                 commitRd_q, commitRd_d;
  logic [31:0]                commitValue_q, commitValue_d;
  logic                       commitStore_q, commitStore_d;
  logic                       clear_q, clear_d;
  logic [31:0]                redirectPc_q, redirectPc_d;

  logic doAlloc, doCommit, mispredict;

  assign rob_full   = (count_q == CNT_FULL);
  assign new_rob_id = clear_q ? '0 : tail_q;
  assign doAlloc    = dec_ready && !rob_full && !clear_q;
  assign doCommit   = busy_q[head_q] && ready_q[head_q] && !clear_q;
  assign mispredict = doCommit && (kind_q[head_q] == KIND_BRANCH) &&
                      (value_q[head_q] != predPc_q[head_q]);

  // The query sees only registered ready bits, so a same-cycle broadcast is not forwarded.
  assign dep_j     = rf_dep_j;
  assign has_dep_j = rf_busy_j && !ready_q[rf_dep_j];
  assign val_j     = rf_busy_j ? value_q[rf_dep_j] : rf_val_j;
  assign dep_k     = rf_dep_k;
  assign has_dep_k = rf_busy_k && !ready_q[rf_dep_k];
  assign val_k     = rf_busy_k ? value_q[rf_dep_k] : rf_val_k;

  assign commit_valid  = commitValid_q;
  assign commit_rob_id = commitId_q;
  assign commit_rd     = commitRd_q;
  assign commit_value  = commitValue_q;
  assign commit_store  = commitStore_q;
  assign clear         = clear_q;
  assign redirect_pc   = redirectPc_q;

  always_comb begin
    busy_d        = busy_q;
    ready_d       = ready_q;
    kind_d        = kind_q;
    rd_d          = rd_q;
    value_d       = value_q;
    predPc_d      = predPc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    commitValid_d = 1'b0;
    commitId_d    = commitId_q;
    commitRd_d    = commitRd_q;
    commitValue_d = commitValue_q;
    commitStore_d = commitStore_q;
    clear_d       = 1'b0;
    redirectPc_d  = redirectPc_q;

    if (doAlloc) begin
      busy_d[tail_q]   = 1'b1;
      ready_d[tail_q]  = 1'b0;
      kind_d[tail_q]   = dec_kind;
      rd_d[tail_q]     = dec_rd;
      predPc_d[tail_q] = dec_pred_pc;
      tail_d           = tail_q + PTR_ONE;
    end

    if (rs_ready && busy_q[rs_rob_id] && !clear_q) begin
      ready_d[rs_rob_id] = 1'b1;
      value_d[rs_rob_id] = rs_value;
    end
    if (lsb_ready && busy_q[lsb_rob_id] && !clear_q) begin
      ready_d[lsb_rob_id] = 1'b1;
      value_d[lsb_rob_id] = lsb_value;
    end

    if (doCommit) begin
      commitValid_d   = 1'b1;
      commitId_d      = head_q;
      commitRd_d      = (kind_q[head_q] == KIND_BRANCH) ? 5'd0 : rd_q[head_q];
      commitValue_d   = value_q[head_q];
      commitStore_d   = (kind_q[head_q] == KIND_STORE);
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
    end

    if (doAlloc && !doCommit) begin
      count_d = count_q + CNT_ONE;
    end else if (!doAlloc && doCommit) begin
      count_d = count_q - CNT_ONE;
    end

    // A mispredict discards everything younger, including anything allocated this edge.
    if (mispredict) begin
      busy_d       = '0;
      ready_d      = '0;
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      clear_d      = 1'b1;
      redirectPc_d = value_q[head_q];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q        <= '0;
      ready_q       <= '0;
      kind_q        <= '0;
      rd_q          <= '0;
      value_q       <= '0;
      predPc_q      <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commitValid_q <= 1'b0;
      commitId_q    <= '0;
      commitRd_q    <= '0;
      commitValue_q <= '0;
      commitStore_q <= 1'b0;
      clear_q       <= 1'b0;
      redirectPc_q  <= '0;
    end else if (rdy_in) begin
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      kind_q        <= kind_d;
      rd_q          <= rd_d;
      value_q       <= value_d;
      predPc_q      <= predPc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commitValid_q <= commitValid_d;
      commitId_q    <= commitId_d;
      commitRd_q    <= commitRd_d;
      commitValue_q <= commitValue_d;
      commitStore_q <= commitStore_d;
      clear_q       <= clear_d;
      redirectPc_q  <= redirectPc_d;
    end
  end

`ifdef ROB_PERF_EN
  logic [31:0] perfCommits_q, perfFlushes_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perfCommits_q <= '0;
      perfFlushes_q <= '0;
    end else if (rdy_in) begin
      if (doCommit)   perfCommits_q <= perfCommits_q + 32'd1;
      if (mispredict) perfFlushes_q <= perfFlushes_q + 32'd1;
    end
  end

  assign perf_commits = perfCommits_q;
  assign perf_flushes = perfFlushes_q;
`endif

endmodule

// File: doc/rob.md
# rob

Reorder buffer for the out-of-order core. It allocates one entry per decoded instruction, answers the operand-dependence query that accompanies every issue into `rs`/`lsb`, and absorbs result broadcasts from `rs` and `lsb`. It retires entries in program order to the register file and store path, and raises `clear` with a redirect PC when a committed branch was mispredicted.

## Interface
- `ROB_WIDTH`, `` `ROB_WIDTH `` (3): entry index width.
- `ROB_SIZE`, `1<<ROB_WIDTH`: number of entries.

Ports:
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset. Synchronous, active-high.
- `rdy_in` in 1: when low, all state holds.
- `dec_ready` in 1: allocate an entry this cycle.
- `dec_kind` in 2: 0 = reg write, 1 = branch, 2 = store.
- `dec_rd` in 5: destination register.
- `dec_pred_pc` in 32: predicted next PC (branches only).
- `new_rob_id` out ROB_WIDTH: id of the entry `dec_ready` allocates (current tail).
- `rob_full` out 1: no free entry.
- `rf_busy_j` in 1, `rf_dep_j` in ROB_WIDTH, `rf_val_j` in 32: register-file rename state for rs1.
- `rf_busy_k` in 1, `rf_dep_k` in ROB_WIDTH, `rf_val_k` in 32: same for rs2.
- `has_dep_j` out 1, `dep_j` out ROB_WIDTH, `val_j` out 32: resolved rs1 query (same names as `rs` inputs).
- `has_dep_k` out 1, `dep_k` out ROB_WIDTH, `val_k` out 32: resolved rs2 query.
- `rs_ready` in 1, `rs_rob_id` in ROB_WIDTH, `rs_value` in 32: ALU broadcast. For branches the value is the resolved next PC.
- `lsb_ready` in 1, `lsb_rob_id` in ROB_WIDTH, `lsb_value` in 32: load/store broadcast.
- `commit_valid` out 1, `commit_rob_id` out ROB_WIDTH, `commit_rd` out 5, `commit_value` out 32, `commit_store` out 1: retirement.
- `clear` out 1, `redirect_pc` out 32: flush and new fetch PC.

## Operation
- Per-entry state: `busy`, `ready`, `kind`, `rd`, `value`, `pred_pc`. Pointers: `head`, `tail`, each ROB_WIDTH bits, wrapping modulo ROB_SIZE. Occupancy: `count`, ROB_WIDTH+1 bits.
- `rob_full = (count == ROB_SIZE)`, combinational.
- Allocate when `dec_ready && !rob_full && !clear`:
  - Write entry[tail] with busy=1, ready=0, kind, rd, pred_pc.
  - Increment tail.
  - `dec_ready` while full is ignored.
- Writeback on `rs_ready` / `lsb_ready`, when the target entry is busy and `clear` is low:
  - Set ready=1 and value.
  - Two broadcasts to different ids in one cycle both apply.
- Query, combinational:
  - `dep_j = rf_dep_j`.
  - `has_dep_j = rf_busy_j && !entry[rf_dep_j].ready`.
  - `val_j = rf_busy_j ? entry[rf_dep_j].value : rf_val_j`.
  - k is identical.
- Commit: when entry[head] is busy && ready and `clear` is low:
  - Pulse `commit_valid` (registered) with id, rd, value.
  - `commit_store = (kind==2)`.
  - Branches present `commit_rd = 0`.
  - Free the entry and increment head.
- Mispredict: a committing branch with `value != pred_pc` additionally triggers the following at the same edge:
  - Every busy bit is cleared.
  - head, tail and count are set to 0.
  - `clear` is driven to 1 and `redirect_pc = value` for exactly one cycle.
- Allocation and commit in the same cycle leave count unchanged.

## Timing
- Reset values: all outputs 0; head, tail and count are 0; all entries are non-busy.
- Commit latency:
  - A broadcast at edge N sets ready.
  - The entry commits at edge N+1.
  - `commit_valid` is high during cycle N+1..N+2.
- At most one commit per cycle.
- `clear` cycle: allocations and broadcasts are ignored; `new_rob_id` reads 0.
- `rdy_in` low:
  - No state changes, and registered outputs hold.
  - Consumers gate `commit_valid`/`clear` with `rdy_in`.
- Reset overrides everything, including an in-flight `clear`.
- `rob_full` reflects current count only. A commit in the same cycle does not free a slot until the next cycle.

## Configuration
- `ROB_PERF_EN` defined: adds 32-bit outputs `perf_commits` and `perf_flushes`.
  - Both reset to 0.
  - `perf_commits` increments on each commit.
  - `perf_flushes` increments on each mispredict.
  - Both wrap at 2^32 and hold when `rdy_in` is low.
- `ROB_PERF_EN` undefined: the ports and counters are absent; all other behaviour is unchanged.

## Test plan
- Reset, then allocate 8 reg-write entries -> `new_rob_id` steps 0..7; `rob_full` goes to 1 after the 8th; a 9th `dec_ready` is ignored and tail stays 0.
- Broadcast `rs_rob_id=2, value=0x55` with head=0 not ready -> no commit. Then broadcast ids 0 and 1 -> commits 0, 1, 2 in order on consecutive cycles, with `commit_value` 0x55 for id 2.
- Query `rf_busy_j=1, rf_dep_j=3`: before any broadcast -> `has_dep_j=1`; after `lsb` broadcast id 3 value 0xABCD -> `has_dep_j=0, val_j=0xABCD`. With `rf_busy_j=0, rf_val_j=7` -> `val_j=7`.
- Branch entry with pred_pc=0x100, broadcast value 0x200 -> at commit, `clear=1, redirect_pc=0x200` for one cycle; count, head and tail are 0; the next allocation gets id 0.
- Full ROB, with commit and `dec_ready` in the same cycle -> the allocation is rejected that cycle and accepted the next cycle at the wrapped tail.
- `rdy_in` held low 3 cycles mid-stream -> pointers, entries and `commit_valid` are unchanged; operation resumes identically. With `ROB_PERF_EN` defined, the counters match the scenario totals.
